// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer family.
// Holds the per-channel slot state and the select-width calculation.
package stream_demux_pkg;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   // A single-channel demux still carries a 1-bit select so ports never collapse to zero width.
   function automatic int calc_sel_w(input int num_out);
      return (num_out > 1) ? $clog2(num_out) : 1;
   endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output holding register for a single demux channel.
// Optional delivered-transfer counter is built when STREAM_DEMUX_CNT_EN is defined.
module stream_demux_slot
   import stream_demux_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_free,
   output slot_state_t       o_state
`ifdef STREAM_DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0]  o_cnt
`endif
);

   slot_state_t       r_state;
   slot_state_t       w_state_nxt;
   logic [DATA_W-1:0] r_data;
   logic              w_drain;

   assign w_drain = (r_state == SLOT_FULL) && i_ready;
   assign o_free  = (r_state == SLOT_EMPTY) || i_ready;
   assign o_state = r_state;
   assign o_data  = r_data;

   // A load while full is only issued when the slot is draining the same cycle, so FULL persists.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SLOT_EMPTY: if (i_load) w_state_nxt = SLOT_FULL;
         SLOT_FULL:  if (i_ready && !i_load) w_state_nxt = SLOT_EMPTY;
         default:    w_state_nxt = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SLOT_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_data;
      end
   end

`ifdef STREAM_DEMUX_CNT_EN
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_drain) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
`else
   logic w_drain_unused;
   assign w_drain_unused = w_drain;
`endif

endmodule

// File: rtl/stream_demux.sv
// Registered valid/ready demultiplexer: unicast to one of NUM_OUT channels or all-or-nothing broadcast.
// Define STREAM_DEMUX_CNT_EN to add per-channel delivered-transfer counters (out_cnt).
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int NUM_OUT = 4,
   parameter int SEL_W   = calc_sel_w(NUM_OUT),
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [SEL_W-1:0]   in_sel,
   input  logic               in_bcast,
   output logic [NUM_OUT-1:0] out_valid,
   input  logic [NUM_OUT-1:0] out_ready,
   output logic [DATA_W-1:0]  out_data [NUM_OUT],
   output logic               drop_pulse
`ifdef STREAM_DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0]   out_cnt [NUM_OUT]
`endif
);

   localparam logic [SEL_W:0] LP_NUM_OUT = (SEL_W + 1)'(NUM_OUT);
   localparam bit             LP_SINGLE  = (NUM_OUT == 1);

   logic [NUM_OUT-1:0] w_free;
   logic [NUM_OUT-1:0] w_hit;
   logic [NUM_OUT-1:0] w_load;
   logic               w_sel_legal;
   logic               w_targets_free;
   logic               w_accept;
   logic               r_drop;
   slot_state_t        w_state [NUM_OUT];

   // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
   // and ready on the input side is combinational from out_ready and the slot states.
   always_comb begin
      w_sel_legal = in_bcast || LP_SINGLE || ({1'b0, in_sel} < LP_NUM_OUT);
      w_hit       = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         w_hit[i] = in_bcast || LP_SINGLE || ({1'b0, in_sel} == (SEL_W + 1)'(i));
      end
      w_targets_free = &(w_free | ~w_hit);
      in_ready       = !rst && (!w_sel_legal || w_targets_free);
   end

   assign w_accept = in_valid && in_ready;
   assign w_load   = w_hit & {NUM_OUT{w_accept && w_sel_legal}};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop <= 1'b0;
      end else begin
         r_drop <= w_accept && !w_sel_legal;
      end
   end

   assign drop_pulse = r_drop;

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
      stream_demux_slot #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_slot (
         .clk     (clk),
         .rst     (rst),
         .i_load  (w_load[g]),
         .i_data  (in_data),
         .i_ready (out_ready[g]),
         .o_data  (out_data[g]),
         .o_free  (w_free[g]),
         .o_state (w_state[g])
`ifdef STREAM_DEMUX_CNT_EN
         ,
         .o_cnt   (out_cnt[g])
`endif
      );

      assign out_valid[g] = (w_state[g] == SLOT_FULL);
   end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance and a 3-channel instance for illegal selects.
// Counter wrap vectors run when STREAM_DEMUX_CNT_EN is defined.
module tb_stream_demux;

   logic clk;
   logic rst;

   // 4-channel instance
   logic       a_in_valid;
   logic       a_in_ready;
   logic [7:0] a_in_data;
   logic [1:0] a_in_sel;
   logic       a_in_bcast;
   logic [3:0] a_out_valid;
   logic [3:0] a_out_ready;
   logic [7:0] a_out_data [4];
   logic       a_drop;
`ifdef STREAM_DEMUX_CNT_EN
   logic [3:0] a_out_cnt [4];
`endif

   // 3-channel instance
   logic       b_in_valid;
   logic       b_in_ready;
   logic [7:0] b_in_data;
   logic [1:0] b_in_sel;
   logic       b_in_bcast;
   logic [2:0] b_out_valid;
   logic [2:0] b_out_ready;
   logic [7:0] b_out_data [3];
   logic       b_drop;
`ifdef STREAM_DEMUX_CNT_EN
   logic [3:0] b_out_cnt [3];
`endif

   int n_checks;
   int n_errors;
   logic [7:0] exp_q[$];
   logic       mon_en;

   stream_demux #(.DATA_W(8), .NUM_OUT(4), .CNT_W(4)) u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (a_in_valid),
      .in_ready   (a_in_ready),
      .in_data    (a_in_data),
      .in_sel     (a_in_sel),
      .in_bcast   (a_in_bcast),
      .out_valid  (a_out_valid),
      .out_ready  (a_out_ready),
      .out_data   (a_out_data),
      .drop_pulse (a_drop)
`ifdef STREAM_DEMUX_CNT_EN
      ,
      .out_cnt    (a_out_cnt)
`endif
   );

   stream_demux #(.DATA_W(8), .NUM_OUT(3), .CNT_W(4)) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (b_in_valid),
      .in_ready   (b_in_ready),
      .in_data    (b_in_data),
      .in_sel     (b_in_sel),
      .in_bcast   (b_in_bcast),
      .out_valid  (b_out_valid),
      .out_ready  (b_out_ready),
      .out_data   (b_out_data),
      .drop_pulse (b_drop)
`ifdef STREAM_DEMUX_CNT_EN
      ,
      .out_cnt    (b_out_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic bc);
      a_in_valid = v;
      a_in_sel   = sel;
      a_in_data  = d;
      a_in_bcast = bc;
   endtask

   // scoreboard for channel 1 deliveries during the backpressure vectors
   always @(negedge clk) begin
      if (mon_en && !rst && a_out_valid[1] && a_out_ready[1]) begin
         if (exp_q.size() == 0) begin
            check("ch1_unexpected", {24'd0, a_out_data[1]}, 32'hFFFF_FFFF);
         end else begin
            check("ch1_order", {24'd0, a_out_data[1]}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      mon_en   = 1'b0;
      rst      = 1'b1;
      drive_a(1'b0, 2'd0, 8'h00, 1'b0);
      a_out_ready = 4'hF;
      b_in_valid  = 1'b0;
      b_in_sel    = 2'd0;
      b_in_data   = 8'h00;
      b_in_bcast  = 1'b0;
      b_out_ready = 3'b111;

      tick();
      tick();
      check("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
      rst = 1'b0;
      tick();
      check("rst_out_valid", {28'd0, a_out_valid}, 32'd0);
      check("rst_drop", {31'd0, a_drop}, 32'd0);
      for (int i = 0; i < 4; i++) check("rst_out_data", {24'd0, a_out_data[i]}, 32'd0);
`ifdef STREAM_DEMUX_CNT_EN
      for (int i = 0; i < 4; i++) check("rst_out_cnt", {28'd0, a_out_cnt[i]}, 32'd0);
`endif

      // basic unicast to channel 2
      drive_a(1'b1, 2'd2, 8'hA5, 1'b0);
      check("uni_in_ready", {31'd0, a_in_ready}, 32'd1);
      tick();
      drive_a(1'b0, 2'd0, 8'h00, 1'b0);
      check("uni_valid", {28'd0, a_out_valid}, 32'h4);
      check("uni_data2", {24'd0, a_out_data[2]}, 32'hA5);
      tick();
      check("uni_drained", {28'd0, a_out_valid}, 32'h0);

      // backpressure on channel 1
      a_out_ready = 4'b1101;
      mon_en      = 1'b1;
      drive_a(1'b1, 2'd1, 8'h11, 1'b0);
      check("bp_first_ready", {31'd0, a_in_ready}, 32'd1);
      exp_q.push_back(8'h11);
      tick();
      drive_a(1'b1, 2'd1, 8'h22, 1'b0);
      check("bp_valid", {28'd0, a_out_valid}, 32'h2);
      check("bp_data_held", {24'd0, a_out_data[1]}, 32'h11);
      check("bp_second_blocked", {31'd0, a_in_ready}, 32'd0);
      tick();
      check("bp_data_stable", {24'd0, a_out_data[1]}, 32'h11);
      check("bp_still_blocked", {31'd0, a_in_ready}, 32'd0);
      a_out_ready = 4'hF;
      #1;
      check("bp_ready_on_drain", {31'd0, a_in_ready}, 32'd1);
      exp_q.push_back(8'h22);
      tick();
      drive_a(1'b0, 2'd0, 8'h00, 1'b0);
      check("bp_valid_kept", {28'd0, a_out_valid}, 32'h2);
      check("bp_new_data", {24'd0, a_out_data[1]}, 32'h22);
      tick();
      mon_en = 1'b0;
      check("bp_drained", {28'd0, a_out_valid}, 32'h0);
      check("bp_queue_empty", exp_q.size(), 32'd0);

      // broadcast all-or-nothing while channel 2 is stalled
      a_out_ready = 4'b1011;
      drive_a(1'b1, 2'd2, 8'h5A, 1'b0);
      tick();
      drive_a(1'b1, 2'd0, 8'h3C, 1'b1);
      check("bc_blocked", {31'd0, a_in_ready}, 32'd0);
      tick();
      check("bc_no_load_valid", {28'd0, a_out_valid}, 32'h4);
      check("bc_ch2_held", {24'd0, a_out_data[2]}, 32'h5A);
      check("bc_ch0_untouched", {24'd0, a_out_data[0]}, 32'h00);
      a_out_ready = 4'hF;
      #1;
      check("bc_ready", {31'd0, a_in_ready}, 32'd1);
      tick();
      drive_a(1'b0, 2'd0, 8'h00, 1'b0);
      check("bc_all_valid", {28'd0, a_out_valid}, 32'hF);
      for (int i = 0; i < 4; i++) check("bc_data", {24'd0, a_out_data[i]}, 32'h3C);
      tick();
      check("bc_drained", {28'd0, a_out_valid}, 32'h0);

      // illegal select on the 3-channel instance
      b_out_ready = 3'b000;
      b_in_valid  = 1'b1;
      b_in_sel    = 2'd3;
      b_in_data   = 8'h77;
      #1;
      check("ill_in_ready", {31'd0, b_in_ready}, 32'd1);
      tick();
      b_in_valid = 1'b0;
      check("ill_drop", {31'd0, b_drop}, 32'd1);
      check("ill_no_valid", {29'd0, b_out_valid}, 32'd0);
      tick();
      check("ill_drop_one_cycle", {31'd0, b_drop}, 32'd0);
      b_in_valid = 1'b1;
      tick();
      check("ill_b2b_drop0", {31'd0, b_drop}, 32'd1);
      tick();
      b_in_valid = 1'b0;
      check("ill_b2b_drop1", {31'd0, b_drop}, 32'd1);
      tick();
      check("ill_b2b_end", {31'd0, b_drop}, 32'd0);
      check("ill_b2b_no_valid", {29'd0, b_out_valid}, 32'd0);

      // reset mid-operation with channels 0 and 3 full
      a_out_ready = 4'h0;
      drive_a(1'b1, 2'd0, 8'h01, 1'b0);
      tick();
      drive_a(1'b1, 2'd3, 8'h09, 1'b0);
      tick();
      b_in_valid = 1'b1;
      b_in_sel   = 2'd3;
      drive_a(1'b1, 2'd1, 8'hEE, 1'b0);
      check("mid_full", {28'd0, a_out_valid}, 32'h9);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", {31'd0, a_in_ready}, 32'd0);
      check("mid_rst_b_in_ready", {31'd0, b_in_ready}, 32'd0);
      tick();
      check("mid_rst_valid", {28'd0, a_out_valid}, 32'h0);
      for (int i = 0; i < 4; i++) check("mid_rst_data", {24'd0, a_out_data[i]}, 32'd0);
      check("mid_rst_drop_a", {31'd0, a_drop}, 32'd0);
      check("mid_rst_drop_b", {31'd0, b_drop}, 32'd0);
      rst = 1'b0;
      b_in_valid = 1'b0;
      drive_a(1'b0, 2'd0, 8'h00, 1'b0);
      tick();
      check("mid_post_valid", {28'd0, a_out_valid}, 32'h0);
      check("mid_post_drop", {31'd0, b_drop}, 32'd0);

`ifdef STREAM_DEMUX_CNT_EN
      // counter wrap: 17 transfers through channel 0 with a 4-bit counter
      a_out_ready = 4'hF;
      for (int i = 0; i < 17; i++) begin
         drive_a(1'b1, 2'd0, 8'(i), 1'b0);
         tick();
      end
      drive_a(1'b0, 2'd0, 8'h00, 1'b0);
      tick();
      check("cnt_ch0_wrap", {28'd0, a_out_cnt[0]}, 32'd1);
      for (int i = 1; i < 4; i++) check("cnt_other", {28'd0, a_out_cnt[i]}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
